// File: rtl/galivan_video_pkg.sv
// Shared video constants and types for the Galivan sprite path.
package galivan_video_pkg;

   localparam int PIX_W       = 8;
   localparam int H_ACT_START = 16;   // hcount of x = 0
   localparam int H_LINE_LAST = 383;  // last hcount of a line, banks swap here

   // Low nibble of a pixel is the colour index; index 0 is see-through.
   localparam logic [3:0] TRANSPARENT = 4'h0;

   typedef logic [PIX_W-1:0] pix_t;

   function automatic logic is_opaque(input logic [3:0] idx);
      return idx != TRANSPARENT;
   endfunction

endpackage

// File: rtl/sprite_linebuf_if.sv
// Bus between the timing generator / sprite engine and the sprite line buffer.
interface sprite_linebuf_if #(
   parameter int PIX_W = 8
);
   logic             ce_pix;
   logic [8:0]       hcount;
   logic             hb;
   logic             wr_en;
   logic [7:0]       wr_x;
   logic [PIX_W-1:0] wr_data;
   logic             line_start;
   logic [PIX_W-1:0] pix_out;
   logic             pix_valid;

   modport master (
      output ce_pix, hcount, hb, wr_en, wr_x, wr_data,
      input  line_start, pix_out, pix_valid
   );

   modport slave (
      input  ce_pix, hcount, hb, wr_en, wr_x, wr_data,
      output line_start, pix_out, pix_valid
   );
endinterface

// File: rtl/linebuf_ram.sv
// 256 x PIX_W simple dual-port line RAM. The read port is asynchronous, so a
// register sampling rdata_o on the same edge as a write to that address
// captures the old contents (read-first from the consumer's point of view).
module linebuf_ram #(
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [7:0]       waddr_i,
   input  logic [PIX_W-1:0] wdata_i,
   input  logic [7:0]       raddr_i,
   output logic [PIX_W-1:0] rdata_o
);

   logic [PIX_W-1:0] mem_q [256];

   // Single write port; contents are never reset.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered 256-pixel sprite line buffer. One bank takes sprite-engine
// writes for the next line while the other is read out for display and
// cleared behind the read, so it comes back empty when the banks swap.
module sprite_linebuf #(
   parameter int PIX_W       = galivan_video_pkg::PIX_W,
   parameter int H_ACT_START = galivan_video_pkg::H_ACT_START,
   parameter int H_LINE_LAST = galivan_video_pkg::H_LINE_LAST
) (
   input  logic              clk,
   input  logic              reset_n,
   sprite_linebuf_if.slave   bus
);
   import galivan_video_pkg::*;

   logic             sel_q, sel_d;          // write bank; display bank is ~sel_q
   logic [1:0]       primed_q, primed_d;    // swaps seen since reset, saturating
   logic             line_start_q, line_start_d;
   logic [PIX_W-1:0] pix_out_q, pix_out_d;
   logic             pix_valid_q, pix_valid_d;

   logic             swap;
   logic             rd_act;
   logic [7:0]       rd_addr;
   logic             wr_opq;
   logic [PIX_W-1:0] disp_data;

   logic [1:0]            bank_we;
   logic [1:0][7:0]       bank_waddr;
   logic [1:0][PIX_W-1:0] bank_wdata;
   logic [1:0][PIX_W-1:0] bank_rdata;

   assign swap    = bus.ce_pix && (bus.hcount == 9'(H_LINE_LAST));
   assign rd_act  = bus.ce_pix && !bus.hb;
   assign rd_addr = 8'(bus.hcount - 9'(H_ACT_START));
   // Transparent sprite pixels are dropped so earlier opaque ones survive.
   assign wr_opq  = bus.wr_en && is_opaque(bus.wr_data[3:0]);

   // Each bank's single write port is shared: the write bank takes sprite
   // pixels, the display bank takes the clear-behind-read. sel_q is the
   // pre-swap value on a swap edge, so a coincident write lands in the bank
   // that is about to be displayed.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic is_wr_bank;
      assign is_wr_bank    = (sel_q == 1'(b));
      assign bank_we[b]    = is_wr_bank ? wr_opq    : rd_act;
      assign bank_waddr[b] = is_wr_bank ? bus.wr_x  : rd_addr;
      assign bank_wdata[b] = is_wr_bank ? bus.wr_data : '0;

      linebuf_ram #(.PIX_W(PIX_W)) u_ram (
         .clk     (clk),
         .we_i    (bank_we[b]),
         .waddr_i (bank_waddr[b]),
         .wdata_i (bank_wdata[b]),
         .raddr_i (rd_addr),
         .rdata_o (bank_rdata[b])
      );
   end

   assign disp_data = sel_q ? bank_rdata[0] : bank_rdata[1];

   // Next-state: bank swap, priming count and the registered pixel output.
   always_comb begin
      sel_d        = sel_q;
      primed_d     = primed_q;
      line_start_d = swap;
      pix_out_d    = pix_out_q;
      pix_valid_d  = pix_valid_q;

      if (swap) begin
         sel_d = ~sel_q;
         if (primed_q != 2'd3) primed_d = primed_q + 2'd1;
      end

      if (bus.ce_pix) begin
         if (bus.hb) begin
            pix_out_d   = '0;
            pix_valid_d = 1'b0;
         end else begin
            // RAM holds garbage after reset until both banks have been read
            // (and so cleared) once; keep the output black until then.
            pix_out_d   = (primed_q >= 2'd2) ? disp_data : '0;
            // After a reset, restart on a line boundary rather than mid-line.
            pix_valid_d = (primed_q != 2'd0);
         end
      end
   end

   // State registers; RAM contents are deliberately left out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q        <= 1'b0;
         primed_q     <= 2'd0;
         line_start_q <= 1'b0;
         pix_out_q    <= '0;
         pix_valid_q  <= 1'b0;
      end else begin
         sel_q        <= sel_d;
         primed_q     <= primed_d;
         line_start_q <= line_start_d;
         pix_out_q    <= pix_out_d;
         pix_valid_q  <= pix_valid_d;
      end
   end

   assign bus.line_start = line_start_q;
   assign bus.pix_out    = pix_out_q;
   assign bus.pix_valid  = pix_valid_q;

endmodule
